// File: rtl/wb_burst_master.sv
// Pipelined Wishbone burst master: turns one {we, addr, len} command into a stream
// of single-word requests, bounded by MAX_OUT outstanding, with an ack watchdog.
module wb_burst_master #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              wb_clk,
    input  logic              wb_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    input  logic [31:0]       wdata,
    output logic              wdata_ready,
    output logic              rdata_valid,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic [31:0]       wb_dat_i
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  acked_q, acked_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              err_q, err_d;

    logic [LEN_W-1:0]  outstanding;
    logic              active, stb, accept, ack_ok, starving;

    always_comb begin
        outstanding = issued_q - acked_q;
        active      = (state_q == REQ) || (state_q == WAIT);
        stb         = (state_q == REQ) && (issued_q < len_q)
                      && ({1'b0, outstanding} < (LEN_W + 1)'(MAX_OUT))
                      && (!we_q || wdata_valid);
        accept      = stb && !wb_stall_i;
        // Acks with nothing outstanding (or outside a burst) are stray and dropped.
        ack_ok      = active && wb_ack_i && (outstanding != '0);
        starving    = (outstanding != '0) && !ack_ok;
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        acked_d  = acked_q;
        wdog_d   = wdog_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    issued_d = '0;
                    acked_d  = '0;
                    wdog_d   = '0;
                    err_d    = 1'b0;
                    state_d  = (cmd_len == '0) ? DONE : REQ;
                end
            end
            REQ, WAIT: begin
                if (accept) issued_d = issued_q + 1'b1;
                if (ack_ok) acked_d = acked_q + 1'b1;
                wdog_d = starving ? wdog_q + 1'b1 : '0;
                if (starving && (wdog_q == WD_W'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if ((state_q == REQ) && accept && (issued_d == len_q)) begin
                    state_d = WAIT;
                end else if ((state_q == WAIT) && (acked_d == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_reset_n) begin
        if (!wb_reset_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            acked_q  <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            acked_q  <= acked_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        cmd_ready   = (state_q == IDLE);
        wb_cyc_o    = active;
        wb_stb_o    = stb;
        wb_we_o     = active && we_q;
        wb_adr_o    = stb ? addr_q + ADDR_W'(issued_q) : '0;
        wb_dat_o    = (stb && we_q) ? wdata : '0;
        wb_sel_o    = stb ? 4'hF : 4'h0;
        wdata_ready = accept && we_q;
        rdata_valid = ack_ok && !we_q;
        rdata       = rdata_valid ? wb_dat_i : '0;
        done        = (state_q == DONE);
        err         = done && err_q;
    end

endmodule
